// File: rtl/ram_arbiter4_pkg.sv
// ram_arbiter4_pkg: shared widths, requester indices and arbiter state encoding
package ram_arbiter4_pkg;
  localparam int AW_DEF = 15;
  localparam int DW_DEF = 16;
  localparam int REQ_CPU = 0;
  localparam int REQ_SCREEN = 1;
  localparam int REQ_KBD = 2;
  localparam int REQ_DMA = 3;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
  function automatic logic [3:0] onehot4(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction
endpackage

// File: rtl/ram_arbiter4_rr_pick4.sv
// rr_pick4: first set mask bit scanning last+1, last+2, ... modulo 4
module rr_pick4 (
  input  logic [3:0] mask_i,
  input  logic [1:0] last_i,
  output logic       any_o,
  output logic [1:0] win_o
);
  always_comb begin
    any_o = |mask_i;
    win_o = last_i;
    for (int k = 4; k >= 1; k--)
      if (mask_i[last_i + 2'(k)]) win_o = last_i + 2'(k);
  end
endmodule

// File: rtl/ram_arbiter4.sv
// ram_arbiter4: round-robin sharing of one registered RAM port among four requesters
module ram_arbiter4 import ram_arbiter4_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [3:0]    req_i,
  input  logic [3:0]    we_i,
  input  logic [4*AW-1:0] addr_i,
  input  logic [4*DW-1:0] wdata_i,
  output logic [3:0]    gnt_o,
  output logic [3:0]    rvalid_o,
  output logic [DW-1:0] rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_we_o,
  input  logic [DW-1:0] mem_rdata_i
);
  state_e state_q, state_d;
  logic [3:0] gnt_q, gnt_d, rv_q, rv_d, mask;
  logic [1:0] last_q, last_d, win;
  logic [7:0] hold_q, hold_d;
  logic busy, xfer, any, at_max;
  // while busy last_q is the granted index, so the owner is excluded from the scan
  assign busy = state_q == BUSY;
  assign xfer = busy & req_i[last_q];
  assign mask = busy ? req_i & ~gnt_q : req_i;
  assign at_max = hold_q == 8'(MAX_HOLD - 1);
  rr_pick4 u_pick (.mask_i(mask), .last_i(last_q), .any_o(any), .win_o(win));
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    hold_d = hold_q;
    rv_d = (xfer & ~we_i[last_q]) ? gnt_q : 4'b0;
    if (!busy || !xfer || (at_max && any)) begin
      state_d = any ? BUSY : IDLE;
      gnt_d = any ? onehot4(win) : 4'b0;
      last_d = any ? win : last_q;
      hold_d = 8'd0;
    end else begin
      hold_d = at_max ? hold_q : hold_q + 8'd1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      gnt_q <= 4'b0;
      rv_q <= 4'b0;
      last_q <= 2'd3;
      hold_q <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      rv_q <= rv_d;
      last_q <= last_d;
      hold_q <= hold_d;
    end
  end
  assign gnt_o = gnt_q;
  assign rvalid_o = rv_q;
  assign rdata_o = mem_rdata_i;
  assign mem_we_o = xfer & we_i[last_q];
  assign mem_addr_o = xfer ? addr_i[last_q*AW +: AW] : '0;
  assign mem_wdata_o = xfer ? wdata_i[last_q*DW +: DW] : '0;
endmodule

// File: tb/tb_ram_arbiter4.sv
// tb_ram_arbiter4: directed plus random stimulus against a cycle-level reference model
module tb_ram_arbiter4;
  localparam int AW = 15;
  localparam int DW = 16;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req, we, gnt, rvalid;
  logic [4*AW-1:0] addr;
  logic [4*DW-1:0] wdata;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic mem_we;
  logic [AW-1:0] a [4];
  logic [DW-1:0] d [4];
  logic [DW-1:0] ram [0:32767];
  logic [DW-1:0] ref_mem [0:32767];
  int own = -1, ptr = 3, run = 0, rv_own = -1;
  logic [DW-1:0] rv_exp;
  int total = 0, bad = 0, we_count = 0;
  always #5 clk = ~clk;
  ram_arbiter4 #(.AW(AW), .DW(DW), .MAX_HOLD(MH)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_rdata_i(mem_rdata)
  );
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      addr[i*AW +: AW] = a[i];
      wdata[i*DW +: DW] = d[i];
    end
  end
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  function automatic int pick(input int from, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) if (m[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction
  // one clock cycle: check outputs for the current inputs, then advance the model
  task automatic tick();
    bit x;
    int w;
    logic [3:0] oth;
    #1;
    x = (own >= 0) ? req[own] : 1'b0;
    chk("gnt", 32'(gnt), (own >= 0) ? 32'(1 << own) : 32'd0);
    chk("mem_we", 32'(mem_we), x ? 32'(we[own]) : 32'd0);
    chk("mem_addr", 32'(mem_addr), x ? 32'(a[own]) : 32'd0);
    chk("mem_wdata", 32'(mem_wdata), x ? 32'(d[own]) : 32'd0);
    chk("rvalid", 32'(rvalid), (rv_own >= 0) ? 32'(1 << rv_own) : 32'd0);
    if (rv_own >= 0) chk("rdata", 32'(rdata), 32'(rv_exp));
    if (mem_we) we_count++;
    if (x && we[own]) ref_mem[a[own]] = d[own];
    if (reset) begin
      own = -1; ptr = 3; run = 0; rv_own = -1;
    end else begin
      if (x && !we[own]) begin
        rv_own = own;
        rv_exp = ref_mem[a[own]];
      end else rv_own = -1;
      if (own < 0) begin
        w = pick(ptr, req);
        if (w >= 0) begin own = w; ptr = w; run = 0; end
      end else if (!x) begin
        w = pick(own, req & ~(4'b0001 << own));
        own = w;
        if (w >= 0) ptr = w;
        run = 0;
      end else begin
        run++;
        oth = req & ~(4'b0001 << own);
        if (run >= MH && oth != 4'b0) begin
          w = pick(own, oth);
          own = w; ptr = w; run = 0;
        end else if (run > MH - 1) run = MH - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 32768; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    ram[15'h6000] = 16'hBEEF;
    ref_mem[15'h6000] = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin a[i] = '0; d[i] = '0; end
    mem_rdata = '0;
    reset = 1'b1; req = 4'b1111; we = 4'b0;
    @(posedge clk); #1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("post_reset_gnt", 32'(gnt), 32'd1);
    req = 4'b0; tick(); tick(); tick();
    req = 4'b0100; a[2] = 15'h6000;
    tick(); tick();
    req = 4'b0; tick(); tick();
    req = 4'b0011;
    tick(); tick(); tick(); tick();
    req = 4'b0010; tick(); tick();
    req = 4'b0; tick(); tick();
    req = 4'b1001;
    repeat (24) tick();
    req = 4'b0; tick(); tick();
    req = 4'b0100; we = 4'b0100; a[2] = 15'h0010; d[2] = 16'h1234;
    tick();
    we_count = 0;
    repeat (20) tick();
    chk("lone_writes", 32'(we_count), 32'd20);
    req = 4'b0; we = 4'b0; tick(); tick();
    req = 4'b1000; we = 4'b1000; a[3] = 15'h0005; d[3] = 16'h5A5A;
    tick(); tick();
    reset = 1'b1; tick();
    reset = 1'b0; req = 4'b1001; we = 4'b0;
    tick();
    chk("reset_ptr_gnt", 32'(gnt), 32'd1);
    repeat (1500) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      we = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        a[i] = 15'($urandom_range(0, 15));
        d[i] = 16'($urandom);
      end
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
